sec_steer_msa_burst: RTL

- Parametrised next-generation secondary-data bus steering for the DP TX main link.
- Holds an MSA symbol image in a double-buffered store. Steers either a repeated Mvid[7:0] symbol or one complete MSA burst onto up to MAX_LANES lane buses, as selected by per-lane blanking steering states.
- Adds over the previous generation:
  - generic lane, symbol and packet sizes;
  - shadow buffering of MSA updates;
  - lane count latched per burst;
  - one burst per blanking entry;
  - abort handling;
  - busy/done status.
- Sits between the stream policy maker (MSA source) and the lane idle/pattern mux.

---
 rtl/sec_steer_msa_burst.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/sec_steer_msa_burst.sv
// Purpose : steers a repeated Mvid symbol or one complete, double-buffered MSA burst onto the DP TX lane buses.
// Latency : 1 cycle from the decoded blanking state to the registered lane data and status.
// Backpress: none; the blanking steering state paces the burst, and MSA loads during a burst go to a shadow buffer.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   td_lane_count, td_vld_data   lane count code (00=1, 01=2, 11=4) and its sample strobe
//   msa_symbols, msa_vld         packed MSA image (symbol 0 in the MSBs) and its load strobe
//   blank_state                  per-lane steering state, 2 bits per lane (00 idle, 01 Mvid, 10 MSA)
//   sec_lane_data, sec_lane_vld  steered symbols (lane k at bits [SYMB_W*(k+1)-1:SYMB_W*k]) and their valid
//   msa_busy, msa_done, msa_abort  burst status; done and abort are single-cycle pulses
module sec_steer_msa_burst #(
    parameter int MAX_LANES = 4,
    parameter int SYMB_W    = 8,
    parameter int NUM_SYMB  = 36,
    parameter int MVID_IDX  = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [1:0]                    td_lane_count,
    input  logic                          td_vld_data,
    input  logic [NUM_SYMB*SYMB_W-1:0]    msa_symbols,
    input  logic                          msa_vld,
    input  logic [MAX_LANES*2-1:0]        blank_state,
    output logic [MAX_LANES*SYMB_W-1:0]   sec_lane_data,
    output logic                          sec_lane_vld,
    output logic                          msa_busy,
    output logic                          msa_done,
    output logic                          msa_abort
);

    localparam int B  = NUM_SYMB / MAX_LANES;   // symbols per lane block
    localparam int CW = $clog2(NUM_SYMB + 1);
    localparam int DW = NUM_SYMB * SYMB_W;
    localparam int LW = MAX_LANES * SYMB_W;

    typedef enum logic [1:0] {S_IDLE, S_MVID, S_SEND, S_HOLD} state_t;

    state_t          state_q;
    logic [DW-1:0]   active_q;
    logic [DW-1:0]   shadow_q;
    logic            pending_q;
    logic [1:0]      lane_cnt_q;
    logic [2:0]      burst_l_q;
    logic [CW-1:0]   cnt_q;

    logic [2:0]      cur_l;
    logic            l_ok;
    logic            same;
    logic [1:0]      dec;
    logic [2:0]      beat_l;
    logic [CW-1:0]   beat_t;
    logic [LW-1:0]   beat_dat;
    logic [LW-1:0]   mvid_dat;
    logic            is_last;
    logic            send_exit;
    int              idx;

    function automatic logic [2:0] lanes_of(input logic [1:0] code);
        case (code)
            2'b00:   lanes_of = 3'd1;
            2'b01:   lanes_of = 3'd2;
            2'b11:   lanes_of = 3'd4;
            default: lanes_of = 3'd0;
        endcase
    endfunction

    function automatic logic [CW-1:0] last_beat(input logic [2:0] l);
        case (l)
            3'd1:    last_beat = CW'(NUM_SYMB - 1);
            3'd2:    last_beat = CW'(NUM_SYMB / 2 - 1);
            default: last_beat = CW'(NUM_SYMB / 4 - 1);
        endcase
    endfunction

    // Decoded steering state: only lanes below the current lane count vote,
    // and any disagreement, reserved code or illegal lane count means idle.
    always_comb begin
        cur_l = lanes_of(lane_cnt_q);
        l_ok  = (cur_l != 3'd0) && (int'(cur_l) <= MAX_LANES);
        same  = 1'b1;
        for (int k = 1; k < MAX_LANES; k++) begin
            if (k < int'(cur_l) && blank_state[2*k +: 2] != blank_state[1:0]) begin
                same = 1'b0;
            end
        end
        dec = 2'b00;
        if (l_ok && same && blank_state[1:0] != 2'b11) begin
            dec = blank_state[1:0];
        end
    end

    // Beat selection: outside SEND this is beat 0 at the current lane count,
    // which is what gets driven on the edge that starts a burst.
    always_comb begin
        beat_l   = (state_q == S_SEND) ? burst_l_q : cur_l;
        beat_t   = (state_q == S_SEND) ? cnt_q : '0;
        beat_dat = '0;
        mvid_dat = '0;
        idx      = 0;
        for (int l = 0; l < MAX_LANES; l++) begin
            if (l < int'(beat_l)) begin
                idx = (int'(beat_t) / B) * int'(beat_l) + l;
                idx = idx * B + int'(beat_t) % B;
                if (idx < NUM_SYMB) begin
                    beat_dat[l*SYMB_W +: SYMB_W] = active_q[(NUM_SYMB-1-idx)*SYMB_W +: SYMB_W];
                end
            end
            if (l < int'(cur_l)) begin
                mvid_dat[l*SYMB_W +: SYMB_W] = active_q[(NUM_SYMB-1-MVID_IDX)*SYMB_W +: SYMB_W];
            end
        end
        is_last   = (beat_t == last_beat(beat_l));
        send_exit = (state_q == S_SEND) && ((dec != 2'b10) || is_last);
    end

    // Double buffer: loads during a burst are parked in the shadow and promoted
    // when the burst ends; a load coinciding with the exit edge is the newest and wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= '0;
            shadow_q  <= '0;
            pending_q <= 1'b0;
        end else if (state_q != S_SEND) begin
            if (msa_vld) begin
                active_q <= msa_symbols;
            end
        end else if (send_exit) begin
            if (msa_vld) begin
                active_q <= msa_symbols;
            end else if (pending_q) begin
                active_q <= shadow_q;
            end
            pending_q <= 1'b0;
        end else if (msa_vld) begin
            shadow_q  <= msa_symbols;
            pending_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            lane_cnt_q    <= 2'b00;
            burst_l_q     <= 3'd0;
            cnt_q         <= '0;
            sec_lane_data <= '0;
            sec_lane_vld  <= 1'b0;
            msa_busy      <= 1'b0;
            msa_done      <= 1'b0;
            msa_abort     <= 1'b0;
        end else begin
            if (td_vld_data) begin
                lane_cnt_q <= td_lane_count;
            end
            msa_done  <= 1'b0;
            msa_abort <= 1'b0;
            if (dec == 2'b10 && state_q != S_HOLD) begin
                // Start or continue a burst.
                sec_lane_data <= beat_dat;
                sec_lane_vld  <= 1'b1;
                msa_busy      <= 1'b1;
                if (state_q != S_SEND) begin
                    burst_l_q <= cur_l;
                end
                if (is_last) begin
                    msa_done <= 1'b1;
                    cnt_q    <= '0;
                    state_q  <= S_HOLD;
                end else begin
                    cnt_q   <= beat_t + 1'b1;
                    state_q <= S_SEND;
                end
            end else if (state_q == S_SEND) begin
                // Steering left MSA before the final beat.
                msa_abort     <= 1'b1;
                sec_lane_data <= '0;
                sec_lane_vld  <= 1'b0;
                msa_busy      <= 1'b0;
                cnt_q         <= '0;
                state_q       <= (dec == 2'b01) ? S_MVID : S_IDLE;
            end else if (dec == 2'b10) begin
                // HOLD: one burst per blanking entry.
                sec_lane_data <= '0;
                sec_lane_vld  <= 1'b0;
                msa_busy      <= 1'b0;
            end else if (dec == 2'b01) begin
                sec_lane_data <= mvid_dat;
                sec_lane_vld  <= 1'b1;
                msa_busy      <= 1'b0;
                state_q       <= S_MVID;
            end else begin
                sec_lane_data <= '0;
                sec_lane_vld  <= 1'b0;
                msa_busy      <= 1'b0;
                state_q       <= S_IDLE;
            end
        end
    end

endmodule
